shadow_reg_stage: RTL and testbench
===================================

Name: shadow_reg_stage

Overview:
- Sequencing stage for shadowed control registers, placed directly upstream of the subreg storage primitive.
- Accepts software writes and enforces the double-write protocol: first write stages, second matching write commits.
- Keeps a committed copy plus an inverted shadow copy, and flags update mismatches and storage corruption.
- The committed value drives the downstream subreg; its reset value is the struct-typed reset parameter.

Parameters:
- DW, 5, data width; must equal $bits(shadow_reg_pkg::ctrl_t).
- RESVAL, shadow_reg_pkg::CTRL_RESET (a=ENUM_ITEM 2'b11, b=3'b000 -> 5'd24), committed reset value, struct-typed.
- TIMEOUT_CYCLES, 16, staged-phase lifetime in cycles; used only with the optional feature; must be >= 2.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- we_i  input  1  software write strobe, one cycle per write.
- wd_i  input  DW  write data, sampled when we_i=1.
- re_i  input  1  software read strobe; clears the staged phase.
- fi_shadow_i  input  1  fault-inject: inverts shadow register bit 0 this cycle (verification only, tie 0).
- q_o  output  DW  committed value, feeds downstream subreg.
- qe_o  output  1  one-cycle pulse, the cycle after a successful commit.
- phase_o  output  1  0=IDLE, 1=STAGED.
- err_update_o  output  1  one-cycle pulse on second-write mismatch.
- err_storage_o  output  1  sticky; committed != ~shadow.

Behaviour:
- Reset (all outputs, registered):
  - committed=RESVAL, shadow=~RESVAL, staged=0, phase=IDLE.
  - qe_o=0, err_update_o=0, err_storage_o=0, q_o=RESVAL.
- FSM IDLE:
  - we_i -> staged<=wd_i, go STAGED.
  - re_i alone -> stay in IDLE.
- FSM STAGED, we_i with wd_i==staged:
  - committed<=wd_i, shadow<=~wd_i, qe_o=1 next cycle, go IDLE.
- FSM STAGED, we_i with wd_i!=staged:
  - committed and shadow unchanged, err_update_o=1 next cycle, go IDLE.
- FSM STAGED, re_i without we_i -> go IDLE, staged value discarded, no error.
- we_i and re_i in the same cycle: the write is processed and the read is ignored for phase purposes.
- Latency: q_o updates the cycle after the committing write; q_o is driven directly from the committed register.
- Storage check:
  - Evaluated every cycle: committed != ~shadow sets err_storage_o on the next edge.
  - err_storage_o clears only on rst_i.
  - A commit does not clear it.
- fi_shadow_i=1 XORs shadow[0] at that edge; it overrides a simultaneous commit's shadow[0] value.
- Reset asserted mid-protocol: the staged value is discarded, returns to the reset state, and no error is reported.
- Widths: all compares are full DW bits; no truncation.

Optional Feature:
- Macro SHADOW_STAGE_TIMEOUT_EN.
- Defined:
  - Counter, width $clog2(TIMEOUT_CYCLES+1), loads 0 on entry to STAGED and increments each cycle in STAGED.
  - On reaching TIMEOUT_CYCLES-1 without a write: go IDLE, discard staged, pulse err_update_o for one cycle.
  - A write arriving in that same terminal cycle takes precedence; the timeout does not fire.
- Undefined: no counter; STAGED persists indefinitely until a write or read.

Decomposition:
- Package shadow_reg_pkg:
  - enum_t (logic [1:0], ENUM_ITEM=2'b11).
  - ctrl_t packed struct {a: logic[1:0], b: logic[2:0]}.
  - CTRL_RESET constant.
  - phase_e {PH_IDLE, PH_STAGED}.
- One sub-module, shadow_reg_check: a combinational committed-vs-~shadow comparator with a registered sticky flag, reusable for other shadowed registers.
- FSM and counter stay in the top module.

Test Plan:
- Reset with default RESVAL -> q_o=24, phase_o=0, both error outputs 0, shadow==~5'd24.
- Write 5'h0A then 5'h0A -> phase 0->1->0; qe_o pulses once; q_o=10 the cycle after the second write.
- Write 5'h0A then 5'h05 -> err_update_o single pulse; q_o stays 24; phase_o=0.
- Write 5'h0A, read, then write 5'h0A -> no commit, phase_o=1 after the last write; q_o=24.
- Pulse fi_shadow_i one cycle -> err_storage_o=1 the next cycle and stays set through a later good commit, until rst_i.
- With SHADOW_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4: write 5'h03 then idle -> phase returns to 0 after 4 cycles with an err_update_o pulse; a second write at cycle 3 commits normally.

Source files
------------

// File: rtl/shadow_reg_pkg.sv
// Shared types for the shadowed control register: field layout, reset value and phase encoding.
package shadow_reg_pkg;

    typedef enum logic [1:0] {
        ENUM_ITEM = 2'b11
    } enum_t;

    typedef struct packed {
        logic [1:0] a;
        logic [2:0] b;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{a: ENUM_ITEM, b: 3'b000};

    typedef enum logic {
        PH_IDLE   = 1'b0,
        PH_STAGED = 1'b1
    } phase_e;

endpackage

// File: rtl/shadow_reg_check.sv
// Storage integrity checker: flags committed != ~shadow and holds the flag until reset.
module shadow_reg_check #(
    parameter int DW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] committed_i,
    input  logic [DW-1:0] shadow_i,
    output logic          err_o
);

    logic mismatch;

    assign mismatch = (committed_i != ~shadow_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (mismatch) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: rtl/shadow_reg_stage.sv
// Double-write sequencing stage in front of a shadowed subreg.
// Optional staged-phase timeout: define SHADOW_STAGE_TIMEOUT_EN.
module shadow_reg_stage
    import shadow_reg_pkg::*;
#(
    parameter int    DW             = 5,
    parameter ctrl_t RESVAL         = CTRL_RESET,
    parameter int    TIMEOUT_CYCLES = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [DW-1:0] wd_i,
    input  logic          re_i,
    input  logic          fi_shadow_i,
    output logic [DW-1:0] q_o,
    output logic          qe_o,
    output logic          phase_o,
    output logic          err_update_o,
    output logic          err_storage_o
);

    localparam logic [DW-1:0] RESVAL_W = DW'(RESVAL);

    if (DW != $bits(ctrl_t)) begin : g_bad_dw
        $error("shadow_reg_stage: DW must equal $bits(ctrl_t)");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("shadow_reg_stage: TIMEOUT_CYCLES must be >= 2");
    end

    phase_e        phase_q;
    logic [DW-1:0] staged_q;
    logic [DW-1:0] committed_q;
    logic [DW-1:0] shadow_q;
    logic          qe_q;
    logic          err_update_q;
    logic          commit;
    logic [DW-1:0] fi_mask;

    assign commit  = (phase_q == PH_STAGED) && we_i && (wd_i == staged_q);
    assign fi_mask = {{(DW-1){1'b0}}, fi_shadow_i};

`ifdef SHADOW_STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] age_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q      <= PH_IDLE;
            staged_q     <= '0;
            committed_q  <= RESVAL_W;
            qe_q         <= 1'b0;
            err_update_q <= 1'b0;
`ifdef SHADOW_STAGE_TIMEOUT_EN
            age_q        <= '0;
`endif
        end else begin
            qe_q         <= 1'b0;
            err_update_q <= 1'b0;
            unique case (phase_q)
                PH_IDLE: begin
                    if (we_i) begin
                        staged_q <= wd_i;
                        phase_q  <= PH_STAGED;
`ifdef SHADOW_STAGE_TIMEOUT_EN
                        age_q    <= '0;
`endif
                    end
                end
                PH_STAGED: begin
                    // A write always resolves the pending stage; a concurrent read is ignored.
                    if (we_i) begin
                        phase_q <= PH_IDLE;
                        if (commit) begin
                            committed_q <= wd_i;
                            qe_q        <= 1'b1;
                        end else begin
                            err_update_q <= 1'b1;
                        end
                    end else if (re_i) begin
                        phase_q <= PH_IDLE;
`ifdef SHADOW_STAGE_TIMEOUT_EN
                    end else if (age_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        phase_q      <= PH_IDLE;
                        err_update_q <= 1'b1;
                    end else begin
                        age_q <= age_q + 1'b1;
`endif
                    end
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    // Fault injection is applied on top of whatever the shadow would otherwise load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= ~RESVAL_W;
        end else begin
            shadow_q <= (commit ? ~wd_i : shadow_q) ^ fi_mask;
        end
    end

    shadow_reg_check #(
        .DW(DW)
    ) u_check (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .committed_i(committed_q),
        .shadow_i   (shadow_q),
        .err_o      (err_storage_o)
    );

    assign q_o          = committed_q;
    assign qe_o         = qe_q;
    assign phase_o      = phase_q;
    assign err_update_o = err_update_q;

endmodule

// File: tb/tb_shadow_reg_stage.sv
// Bench for shadow_reg_stage: directed vector table plus randomized run against a protocol model.
module tb_shadow_reg_stage;
    import shadow_reg_pkg::*;

    localparam int TO = 16;
    localparam logic [4:0] RES = 5'd24;

    logic       clk = 1'b0;
    logic       rst, we, re, fi;
    logic [4:0] wd;
    logic [4:0] q;
    logic       qe, ph, eu, es;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shadow_reg_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .we_i         (we),
        .wd_i         (wd),
        .re_i         (re),
        .fi_shadow_i  (fi),
        .q_o          (q),
        .qe_o         (qe),
        .phase_o      (ph),
        .err_update_o (eu),
        .err_storage_o(es)
    );

    typedef struct {
        logic       rst, we, re, fi;
        logic [4:0] wd;
        logic [4:0] q;
        logic       qe, ph, eu, es;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic w, input logic rd, input logic f,
                       input logic [4:0] d, input logic [4:0] eq, input logic eqe,
                       input logic eph, input logic eeu, input logic ees);
        vec_t v;
        v.rst = r; v.we = w; v.re = rd; v.fi = f; v.wd = d;
        v.q = eq; v.qe = eqe; v.ph = eph; v.eu = eeu; v.es = ees;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic r, input logic w, input logic rd,
                               input logic f, input logic [4:0] d);
        rst = r; we = w; re = rd; fi = f; wd = d;
        @(posedge clk);
        #1;
    endtask

    // Protocol model: at most one pending first-write, tracked as a queue.
    logic [4:0] m_q, m_sh;
    logic [4:0] pending[$];
    int         m_age;
    logic       m_qe, m_eu, m_es;

    task automatic model_step(input logic r, input logic w, input logic rd,
                              input logic f, input logic [4:0] d);
        logic [4:0] first;
        logic [4:0] sh_n;
        logic       es_n;
        if (r) begin
            m_q = RES; m_sh = ~RES; pending.delete();
            m_qe = 1'b0; m_eu = 1'b0; m_es = 1'b0; m_age = 0;
        end else begin
            es_n = m_es | (m_q != ~m_sh);
            m_qe = 1'b0; m_eu = 1'b0;
            sh_n = m_sh;
            if (pending.size() == 0) begin
                if (w) begin
                    pending.push_back(d);
                    m_age = 0;
                end
            end else if (w) begin
                first = pending.pop_front();
                if (d == first) begin
                    m_q = d; sh_n = ~d; m_qe = 1'b1;
                end else begin
                    m_eu = 1'b1;
                end
            end else if (rd) begin
                pending.delete();
            end else begin
`ifdef SHADOW_STAGE_TIMEOUT_EN
                if (m_age == TO - 1) begin
                    pending.delete();
                    m_eu = 1'b1;
                end else begin
                    m_age++;
                end
`endif
            end
            sh_n[0] = sh_n[0] ^ f;
            m_sh = sh_n;
            m_es = es_n;
        end
    endtask

    task automatic model_cycle(input string tag, input logic r, input logic w,
                               input logic rd, input logic f, input logic [4:0] d);
        model_step(r, w, rd, f, d);
        drive_cycle(r, w, rd, f, d);
        chk({tag, ".q"},  q,  m_q);
        chk({tag, ".qe"}, {4'b0, qe}, {4'b0, m_qe});
        chk({tag, ".ph"}, {4'b0, ph}, {4'b0, (pending.size() != 0)});
        chk({tag, ".eu"}, {4'b0, eu}, {4'b0, m_eu});
        chk({tag, ".es"}, {4'b0, es}, {4'b0, m_es});
    endtask

    initial begin
        logic [4:0] last_wd;
        logic       rw, rr, rf, rrst;
        logic [4:0] rd_v;
        rst = 1'b0; we = 1'b0; re = 1'b0; fi = 1'b0; wd = '0;

        //  rst we re fi wd      q    qe ph eu es
        add(1, 0, 0, 0, 5'h00, 5'd24, 0, 0, 0, 0);
        add(0, 1, 0, 0, 5'h0A, 5'd24, 0, 1, 0, 0);
        add(0, 1, 0, 0, 5'h0A, 5'd10, 1, 0, 0, 0);
        add(0, 0, 0, 0, 5'h00, 5'd10, 0, 0, 0, 0);
        add(1, 0, 0, 0, 5'h00, 5'd24, 0, 0, 0, 0);
        add(0, 1, 0, 0, 5'h0A, 5'd24, 0, 1, 0, 0);
        add(0, 1, 0, 0, 5'h05, 5'd24, 0, 0, 1, 0);
        add(0, 0, 0, 0, 5'h00, 5'd24, 0, 0, 0, 0);
        add(0, 1, 0, 0, 5'h0A, 5'd24, 0, 1, 0, 0);
        add(0, 0, 1, 0, 5'h00, 5'd24, 0, 0, 0, 0);
        add(0, 1, 0, 0, 5'h0A, 5'd24, 0, 1, 0, 0);
        add(0, 0, 1, 0, 5'h00, 5'd24, 0, 0, 0, 0);
        add(0, 0, 0, 1, 5'h00, 5'd24, 0, 0, 0, 0);
        add(0, 0, 0, 0, 5'h00, 5'd24, 0, 0, 0, 1);
        add(0, 1, 0, 0, 5'h07, 5'd24, 0, 1, 0, 1);
        add(0, 1, 0, 0, 5'h07, 5'd7,  1, 0, 0, 1);
        add(0, 0, 0, 0, 5'h00, 5'd7,  0, 0, 0, 1);
        add(1, 0, 0, 0, 5'h00, 5'd24, 0, 0, 0, 0);
        add(0, 1, 1, 0, 5'h0A, 5'd24, 0, 1, 0, 0);
        add(0, 1, 1, 0, 5'h0A, 5'd10, 1, 0, 0, 0);
        add(0, 1, 0, 0, 5'h1F, 5'd10, 0, 1, 0, 0);
        add(0, 1, 0, 0, 5'h1E, 5'd10, 0, 0, 1, 0);
        add(0, 1, 0, 0, 5'h11, 5'd10, 0, 1, 0, 0);
        add(1, 0, 0, 0, 5'h00, 5'd24, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive_cycle(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].fi, tbl[i].wd);
            chk($sformatf("vec%0d.q", i),  q, tbl[i].q);
            chk($sformatf("vec%0d.qe", i), {4'b0, qe}, {4'b0, tbl[i].qe});
            chk($sformatf("vec%0d.ph", i), {4'b0, ph}, {4'b0, tbl[i].ph});
            chk($sformatf("vec%0d.eu", i), {4'b0, eu}, {4'b0, tbl[i].eu});
            chk($sformatf("vec%0d.es", i), {4'b0, es}, {4'b0, tbl[i].es});
        end
        chk("reset_shadow", dut.shadow_q, 5'b00111);

        // Long hold in STAGED, then resolve with a matching write.
        model_cycle("hold_rst", 1, 0, 0, 0, 5'h00);
        model_cycle("hold_w1", 0, 1, 0, 0, 5'h0A);
        for (int i = 0; i < 20; i++) model_cycle($sformatf("hold%0d", i), 0, 0, 0, 0, 5'h00);
        model_cycle("hold_w2", 0, 1, 0, 0, 5'h0A);
        model_cycle("hold_w3", 0, 1, 0, 0, 5'h0A);
        model_cycle("hold_w4", 0, 1, 0, 0, 5'h0A);

        // Fault injection coinciding with a commit.
        model_cycle("fic_w1", 0, 1, 0, 0, 5'h13);
        model_cycle("fic_w2", 0, 1, 0, 1, 5'h13);
        model_cycle("fic_idle", 0, 0, 0, 0, 5'h00);
        model_cycle("fic_idle2", 0, 0, 0, 0, 5'h00);

        model_cycle("rnd_rst", 1, 0, 0, 0, 5'h00);
        last_wd = 5'h00;
        for (int i = 0; i < 400; i++) begin
            rrst = ($urandom_range(0, 99) < 2);
            rw   = ($urandom_range(0, 99) < 45);
            rr   = ($urandom_range(0, 99) < 12);
            rf   = ($urandom_range(0, 99) < 3);
            rd_v = ($urandom_range(0, 2) != 0) ? last_wd : 5'($urandom);
            if (rw) last_wd = rd_v;
            model_cycle($sformatf("rnd%0d", i), rrst, rw, rr, rf, rd_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
